// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count
module elastic_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
  logic [CW-1:0]                count_q, count_d;
  logic [DEPTH:0]               r;
  logic [DEPTH:0]               uv;
  logic [DEPTH:0][WIDTH-1:0]    ud;
  assign uv = {v_q, in_valid};
  assign ud = {d_q, in_data};
  always_comb begin
    logic acc;
    r = '0;
    acc = out_ready;
    r[DEPTH] = acc;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc = !v_q[i] || acc;
      r[i] = acc;
    end
  end
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = r[i] ? uv[i] : v_q[i];
      d_d[i] = (r[i] && uv[i]) ? ud[i] : d_q[i];
      count_d = count_d + CW'(v_d[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      v_q <= '0;
      count_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      count_q <= count_d;
    end
  end
  assign in_ready = r[0] && !flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data = d_q[DEPTH-1];
  assign count = count_q;
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed self-checking bench for a 3-stage, 16-bit elastic_pipe
module tb_elastic_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_data;
  logic [1:0]  count;
  int errors = 0;
  int checks = 0;

  elastic_pipe #(.WIDTH(16), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    int ec;
    out_ready = 1;
    for (int s = 0; s < 14; s++) begin
      in_valid = (s < 10);
      in_data = 16'(s);
      #1;
      ec = 0;
      for (int k = 0; k < 10; k++) if (k >= s - 3 && k <= s - 1) ec++;
      checks++; if (out_valid !== (s >= 3 && s <= 12)) begin errors++; $display("FAIL stream_valid slot=%0d got=%b exp=%b", s, out_valid, (s >= 3 && s <= 12)); end
      if (s >= 3 && s <= 12) begin
        checks++; if (out_data !== 16'(s - 3)) begin errors++; $display("FAIL stream_data slot=%0d got=%h exp=%h", s, out_data, 16'(s - 3)); end
      end
      checks++; if (count !== 2'(ec)) begin errors++; $display("FAIL stream_count slot=%0d got=%0d exp=%0d", s, count, ec); end
      if (s < 10) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready slot=%0d got=%b exp=1", s, in_ready); end
      end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_stall();
    out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1; in_data = 16'h00A1 + 16'(s);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept slot=%0d got=%b exp=1", s, in_ready); end
      tick();
    end
    in_data = 16'h00A4;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready hold=%0d got=%b exp=0", s, in_ready); end
      checks++; if (count !== 2'd3) begin errors++; $display("FAIL stall_count hold=%0d got=%0d exp=3", s, count); end
      checks++; if (out_data !== 16'h00A1 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold hold=%0d got=%b/%h exp=1/00a1", s, out_valid, out_data); end
      tick();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got=%b exp=1", in_ready); end
    for (int s = 0; s < 4; s++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h00A1 + 16'(s)) begin errors++; $display("FAIL stall_drain idx=%0d got=%b/%h exp=1/%h", s, out_valid, out_data, 16'h00A1 + 16'(s)); end
      tick();
      in_valid = 0;
    end
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL stall_empty got=%b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1; in_data = 16'h00A1 + 16'(s);
      tick();
    end
    in_data = 16'h00B0; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 16'h00A1) begin errors++; $display("FAIL b2b_first got=%h exp=00a1", out_data); end
    tick();
    in_valid = 0;
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", count); end
    checks++; if (out_data !== 16'h00A2) begin errors++; $display("FAIL b2b_next got=%h exp=00a2", out_data); end
    tick();
    checks++; if (out_data !== 16'h00A3) begin errors++; $display("FAIL b2b_a3 got=%h exp=00a3", out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00B0) begin errors++; $display("FAIL b2b_b0 got=%b/%h exp=1/00b0", out_valid, out_data); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_bubble();
    out_ready = 0;
    in_valid = 1; in_data = 16'h0011;
    tick();
    in_valid = 0;
    tick(); tick();
    in_valid = 1; in_data = 16'h0022;
    tick();
    in_valid = 0;
    tick();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bubble_count got=%0d exp=2", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
    checks++; if (dut.v_q !== 3'b110) begin errors++; $display("FAIL bubble_stages got=%b exp=110", dut.v_q); end
    out_ready = 1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0011) begin errors++; $display("FAIL bubble_first got=%b/%h exp=1/0011", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0022) begin errors++; $display("FAIL bubble_second got=%b/%h exp=1/0022", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 16'h0055;
    tick();
    in_data = 16'h0066;
    tick();
    in_valid = 0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
    flush = 1; in_valid = 1; in_data = 16'h0033;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_leak slot=%0d got=%b/%0d exp=0/0", s, out_valid, count); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1; in_data = 16'h0071 + 16'(s);
      tick();
    end
    in_valid = 0;
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL rstmid_pre_count got=%0d exp=3", count); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rstmid_out_data got=%h exp=0000", out_data); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    in_valid = 1; in_data = 16'h0044; out_ready = 1;
    tick();
    in_valid = 0;
    for (int s = 0; s < 2; s++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early slot=%0d got=%b exp=0", s, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0044) begin errors++; $display("FAIL rstmid_emerge got=%b/%h exp=1/0044", out_valid, out_data); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_bubble();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
